// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared constants and types for the registered 1-to-4 demultiplexer.
//   DEMUX_CHANNELS : number of downstream channels
//   DEMUX_SEL_W    : width of the channel select
//   COUNT_W        : width of the optional delivered-word counters
//   demux_sel_t    : channel select type
// ---------------------------------------------------------------------------
package demux_pkg;

    localparam int DEMUX_CHANNELS = 4;
    localparam int DEMUX_SEL_W    = 2;
    localparam int COUNT_W        = 8;

    typedef logic [DEMUX_SEL_W-1:0] demux_sel_t;

endpackage

// File: rtl/demux_channel_buffer.sv
// ---------------------------------------------------------------------------
// demux_channel_buffer
// One-word holding register for a single demultiplexer output channel.
// Build option: DEMUX_COUNT_EN adds a saturating delivered-word counter.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : capture load_data this cycle (already qualified upstream)
//   load_data    : word to capture
//   drain_ready  : downstream consumer takes the held word this cycle
//   full         : channel holds a word (drives out_valid[k])
//   data         : held word (drives out_data_k)
//   count        : number of drains, saturating (DEMUX_COUNT_EN only)
// ---------------------------------------------------------------------------
module demux_channel_buffer
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain_ready,
    output logic             full,
    output logic [WIDTH-1:0] data
`ifdef DEMUX_COUNT_EN
    ,
    output logic [COUNT_W-1:0] count
`endif
);

    logic drain;

    assign drain = full && drain_ready;

    // A load takes priority over a drain, so a drain and a load in the same
    // cycle replace the word without dropping full (no bubble).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

`ifdef DEMUX_COUNT_EN
    // Counter sticks at all-ones until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (drain && (count != {COUNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/one_to_four_demultiplexer.sv
// ---------------------------------------------------------------------------
// one_to_four_demultiplexer
// Registered 1-to-4 demultiplexer: steers words from one valid/ready source
// to one of four channels, each with its own one-word holding register so a
// stalled channel does not block the others.
// Build option: DEMUX_COUNT_EN adds count_0..count_3 delivered-word counters.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_data, in_sel, in_valid: source word, destination channel, valid
//   in_ready                 : combinational; word accepted when valid&&ready
//   out_data_0..out_data_3   : per-channel held word
//   out_valid[3:0]           : channel k holds a word
//   out_ready[3:0]           : channel k consumer takes its word
//   count_0..count_3         : saturating drain counters (DEMUX_COUNT_EN)
// ---------------------------------------------------------------------------
module one_to_four_demultiplexer
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in_data,
    input  demux_sel_t                in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_data_0,
    output logic [WIDTH-1:0]          out_data_1,
    output logic [WIDTH-1:0]          out_data_2,
    output logic [WIDTH-1:0]          out_data_3,
    output logic [DEMUX_CHANNELS-1:0] out_valid,
    input  logic [DEMUX_CHANNELS-1:0] out_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [COUNT_W-1:0]        count_0,
    output logic [COUNT_W-1:0]        count_1,
    output logic [COUNT_W-1:0]        count_2,
    output logic [COUNT_W-1:0]        count_3
`endif
);

    logic                      accept;
    logic [DEMUX_CHANNELS-1:0] load;
    logic [WIDTH-1:0]          ch_data [DEMUX_CHANNELS];
`ifdef DEMUX_COUNT_EN
    logic [COUNT_W-1:0]        ch_count [DEMUX_CHANNELS];
`endif

    // The target channel can take a word if it is empty or is being drained
    // this same cycle; this does not look at in_valid.
    assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
    assign accept   = in_valid && in_ready;

    always_comb begin
        load         = '0;
        load[in_sel] = accept;
    end

    for (genvar k = 0; k < DEMUX_CHANNELS; k++) begin : g_chan
        demux_channel_buffer #(
            .WIDTH(WIDTH)
        ) u_buf (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load[k]),
            .load_data  (in_data),
            .drain_ready(out_ready[k]),
            .full       (out_valid[k]),
            .data       (ch_data[k])
`ifdef DEMUX_COUNT_EN
            ,
            .count      (ch_count[k])
`endif
        );
    end

    assign out_data_0 = ch_data[0];
    assign out_data_1 = ch_data[1];
    assign out_data_2 = ch_data[2];
    assign out_data_3 = ch_data[3];

`ifdef DEMUX_COUNT_EN
    assign count_0 = ch_count[0];
    assign count_1 = ch_count[1];
    assign count_2 = ch_count[2];
    assign count_3 = ch_count[3];
`endif

endmodule

// File: tb/tb_one_to_four_demultiplexer.sv
// ---------------------------------------------------------------------------
// tb_one_to_four_demultiplexer
// Self-checking bench for one_to_four_demultiplexer. The reference model keeps
// one queue per channel (at most one word deep) plus a drain tally.
// Build option: DEMUX_COUNT_EN enables the counter checks.
// ---------------------------------------------------------------------------
module tb_one_to_four_demultiplexer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data_0, out_data_1, out_data_2, out_data_3;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
`ifdef DEMUX_COUNT_EN
    logic [7:0] count_0, count_1, count_2, count_3;
    logic [7:0] cnt [4];
`endif
    logic [7:0] od [4];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] mq [4][$];
    int         drains [4];

    typedef struct {
        logic [7:0] d;
        logic [1:0] s;
        logic       v;
        logic [3:0] r;
        logic       expRdy;
        logic [3:0] expValid;
        int         chan;
        logic [7:0] chanData;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    one_to_four_demultiplexer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data_0(out_data_0),
        .out_data_1(out_data_1),
        .out_data_2(out_data_2),
        .out_data_3(out_data_3),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_COUNT_EN
        ,
        .count_0   (count_0),
        .count_1   (count_1),
        .count_2   (count_2),
        .count_3   (count_3)
`endif
    );

    assign od[0] = out_data_0;
    assign od[1] = out_data_1;
    assign od[2] = out_data_2;
    assign od[3] = out_data_3;
`ifdef DEMUX_COUNT_EN
    assign cnt[0] = count_0;
    assign cnt[1] = count_1;
    assign cnt[2] = count_2;
    assign cnt[3] = count_3;
`endif

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic modelReady(input logic [1:0] s, input logic [3:0] r);
        return (mq[s].size() == 0) || r[s];
    endfunction

    task automatic modelClear();
        for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            drains[k] = 0;
        end
    endtask

    // Compare registered outputs against the model
    task automatic checkOutput();
        for (int k = 0; k < 4; k++) begin
            checkEq($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(mq[k].size() != 0));
            if (mq[k].size() != 0)
                checkEq($sformatf("out_data_%0d", k), 32'(od[k]), 32'(mq[k][0]));
`ifdef DEMUX_COUNT_EN
            checkEq($sformatf("count_%0d", k), 32'(cnt[k]), (drains[k] > 255) ? 32'd255 : 32'(drains[k]));
`endif
        end
    endtask

    // One clock cycle: drive at negedge, check in_ready, advance model at edge
    task automatic applyStimulus(input logic [7:0] d, input logic [1:0] s, input logic v,
                                 input logic [3:0] r, output logic rdySeen, output logic accepted);
        logic exp;
        @(negedge clk);
        in_data   = d;
        in_sel    = s;
        in_valid  = v;
        out_ready = r;
        #1;
        exp     = modelReady(s, r);
        rdySeen = in_ready;
        checkEq("in_ready", 32'(in_ready), 32'(exp));
        accepted = v && exp;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (mq[k].size() != 0 && r[k]) begin
                mq[k].delete(0);
                drains[k]++;
            end
        end
        if (accepted) mq[s].push_back(d);
        checkOutput();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        modelClear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic rdy, acc;
        logic [7:0] d;
        logic [1:0] s;
        logic       v;
        logic       pending;
        int         nAcc;

        rst_n     = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        in_valid  = 1'b0;
        out_ready = '0;
        modelClear();

        tbl[0] = '{8'hA5, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0100, 2, 8'hA5};
        tbl[1] = '{8'h3C, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0110, 1, 8'h3C};
        tbl[2] = '{8'h77, 2'd1, 1'b1, 4'b0000, 1'b0, 4'b0110, 1, 8'h3C};
        tbl[3] = '{8'h77, 2'd3, 1'b1, 4'b0000, 1'b1, 4'b1110, 3, 8'h77};
        tbl[4] = '{8'h11, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b1111, 0, 8'h11};
        tbl[5] = '{8'h22, 2'd0, 1'b1, 4'b0001, 1'b1, 4'b1111, 0, 8'h22};
        tbl[6] = '{8'h00, 2'd0, 1'b0, 4'b0110, 1'b0, 4'b1001, 0, 8'h22};
        tbl[7] = '{8'h55, 2'd1, 1'b1, 4'b1001, 1'b1, 4'b0010, 1, 8'h55};
        tbl[8] = '{8'h00, 2'd0, 1'b0, 4'b0010, 1'b1, 4'b0000, 1, 8'h55};

        // Reset state
        repeat (2) @(negedge clk);
        checkEq("reset out_valid", 32'(out_valid), 32'h0);
        for (int k = 0; k < 4; k++)
            checkEq($sformatf("reset out_data_%0d", k), 32'(od[k]), 32'h0);
        checkEq("reset in_ready", 32'(in_ready), 32'h1);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i].d, tbl[i].s, tbl[i].v, tbl[i].r, rdy, acc);
            checkEq($sformatf("tbl%0d in_ready", i), 32'(rdy), 32'(tbl[i].expRdy));
            checkEq($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].expValid));
            checkEq($sformatf("tbl%0d out_data", i), 32'(od[tbl[i].chan]), 32'(tbl[i].chanData));
        end

        // Four back-to-back words to channel 0 while it drains: one per cycle
        nAcc = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'hC0 + 8'(i), 2'd0, 1'b1, 4'b0001, rdy, acc);
            if (acc) nAcc++;
        end
        checkEq("stream accepted", 32'(nAcc), 32'd4);
        checkEq("stream last word", 32'(out_data_0), 32'hC3);
        applyStimulus(8'h00, 2'd0, 1'b0, 4'b1111, rdy, acc);

        // Fill every channel, then hit reset in the middle of a cycle
        for (int i = 0; i < 4; i++)
            applyStimulus(8'h90 + 8'(i), 2'(i), 1'b1, 4'b0000, rdy, acc);
        checkEq("prefill out_valid", 32'(out_valid), 32'hF);
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = 2'd1;
        in_data  = 8'hEE;
        #2;
        rst_n = 1'b0;
        #1;
        modelClear();
        checkEq("async out_valid", 32'(out_valid), 32'h0);
        for (int k = 0; k < 4; k++)
            checkEq($sformatf("async out_data_%0d", k), 32'(od[k]), 32'h0);
        checkEq("async in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        checkEq("no capture in reset", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Random traffic; a refused word is held until accepted
        pending = 1'b0;
        d = '0;
        s = '0;
        v = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!pending) begin
                d = 8'($urandom);
                s = 2'($urandom);
                v = 1'($urandom_range(0, 3) != 0);
            end
            applyStimulus(d, s, v, 4'($urandom), rdy, acc);
            pending = v && !acc;
        end

`ifdef DEMUX_COUNT_EN
        // Saturation: 301 cycles of send+drain on channel 2 give 300 drains
        doReset();
        for (int i = 0; i < 301; i++)
            applyStimulus(8'(i), 2'd2, 1'b1, 4'b0100, rdy, acc);
        checkEq("sat count_2", 32'(count_2), 32'd255);
        checkEq("sat count_0", 32'(count_0), 32'd0);
        checkEq("sat count_1", 32'(count_1), 32'd0);
        checkEq("sat count_3", 32'(count_3), 32'd0);
        doReset();
        #1;
        checkEq("reset count_2", 32'(count_2), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
